// File: rtl/combo_lock_state_machine.sv
// ---------------------------------------------------------------------------
// combo_lock_state_machine
//
// Combination lock controller. A code is submitted on each rising edge of
// trig. A correct code unlocks the block. MAX_FAILS consecutive wrong codes
// put it into a timed LOCKOUT. While in LOCKOUT every submission and every
// relock request is ignored until LOCKOUT_CYCLES clock cycles have passed.
//
// Parameters
//   PIN            unlock code (16 bits)
//   MAX_FAILS      consecutive wrong attempts that trigger lockout (1..15)
//   LOCKOUT_CYCLES cycles spent in LOCKOUT before returning to LOCKED (1..65535)
//
// Ports
//   clk      in   1   single clock, rising edge
//   rst      in   1   asynchronous, active-high reset
//   pinCode  in  16   entered code, sampled on a detected trig rising edge
//   trig     in   1   submit request (level); only its rising edge counts
//   lock     in   1   relock request (level), honoured only while UNLOCKED
//   state    out  2   registered state: 00 LOCKED, 01 UNLOCKED, 10 LOCKOUT
// ---------------------------------------------------------------------------
module combo_lock_state_machine #(
  parameter logic [15:0] PIN            = 16'hCACA,
  parameter int          MAX_FAILS      = 4,
  parameter int          LOCKOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pinCode,
  input  logic        trig,
  input  logic        lock,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'b00,
    ST_UNLOCKED = 2'b01,
    ST_LOCKOUT  = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_t;

  localparam logic [3:0]  MAX_FAILS_C = 4'(MAX_FAILS);
  localparam logic [15:0] LOCKOUT_C   = 16'(LOCKOUT_CYCLES);

  state_t      cur_state;
  state_t      nxt_state;
  logic [3:0]  fail_q;
  logic [3:0]  fail_d;
  logic [15:0] timer_q;
  logic [15:0] timer_d;
  logic        trig_d;
  logic        trig_edge;

  // trig_d resets to 1 so that a trig already high when reset is released
  // is not mistaken for a fresh submission.
  assign trig_edge = trig & ~trig_d;

  // State register. rst acts immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= ST_LOCKED;
      fail_q    <= 4'd0;
      timer_q   <= 16'd0;
      trig_d    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, independent of statement order.
      cur_state <= nxt_state;
      fail_q    <= fail_d;
      timer_q   <= timer_d;
      trig_d    <= trig;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    nxt_state = cur_state;
    fail_d    = fail_q;
    timer_d   = timer_q;

    unique case (cur_state)
      ST_LOCKED: begin
        // lock has no effect here; only trig edges matter.
        if (trig_edge) begin
          if (pinCode == PIN) begin
            nxt_state = ST_UNLOCKED;
            fail_d    = 4'd0;
          end else begin
            fail_d = fail_q + 4'd1;
            if (fail_q + 4'd1 == MAX_FAILS_C) begin
              nxt_state = ST_LOCKOUT;
              timer_d   = LOCKOUT_C;
            end
          end
        end
      end

      ST_UNLOCKED: begin
        // trig edges are discarded; lock alone decides the exit.
        fail_d  = 4'd0;
        timer_d = 16'd0;
        if (lock) begin
          nxt_state = ST_LOCKED;
        end
      end

      ST_LOCKOUT: begin
        // The timer was loaded on entry; leaving on the edge where it would
        // hit zero keeps the state at LOCKOUT for exactly LOCKOUT_CYCLES.
        if (timer_q <= 16'd1) begin
          nxt_state = ST_LOCKED;
          fail_d    = 4'd0;
          timer_d   = 16'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      default: begin
        // Recovery from the unused encoding.
        nxt_state = ST_LOCKED;
        fail_d    = 4'd0;
        timer_d   = 16'd0;
      end
    endcase
  end

  // Output logic: state is the register itself, with no input path.
  always_comb begin
    state = cur_state;
  end

endmodule

// File: tb/tb_combo_lock_state_machine.sv
// ---------------------------------------------------------------------------
// tb_combo_lock_state_machine
//
// Self-checking bench for combo_lock_state_machine (LOCKOUT_CYCLES = 8).
// A behavioural model predicts the state after each clock edge. The
// prediction is queued when the inputs are driven, then popped and compared
// once the DUT has clocked.
// ---------------------------------------------------------------------------
module tb_combo_lock_state_machine;

  localparam logic [15:0] TB_PIN       = 16'hCACA;
  localparam int          TB_MAX_FAILS = 4;
  localparam int          TB_LOCKOUT   = 8;

  localparam logic [1:0] S_LOCKED   = 2'b00;
  localparam logic [1:0] S_UNLOCKED = 2'b01;
  localparam logic [1:0] S_LOCKOUT  = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pinCode = 16'h0000;
  logic        trig = 1'b0;
  logic        lock = 1'b0;
  logic [1:0]  state;

  combo_lock_state_machine #(
    .PIN           (TB_PIN),
    .MAX_FAILS     (TB_MAX_FAILS),
    .LOCKOUT_CYCLES(TB_LOCKOUT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pinCode(pinCode),
    .trig   (trig),
    .lock   (lock),
    .state  (state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int lo_cnt   = 0;

  typedef struct {
    string      tag;
    logic [1:0] exp;
  } sb_item_t;

  sb_item_t sb[$];

  // Reference model.
  logic [1:0] m_state;
  int         m_fails;
  int         m_remaining;
  logic       m_trigd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state     = S_LOCKED;
    m_fails     = 0;
    m_remaining = 0;
    m_trigd     = 1'b1;
  endtask

  task automatic model_step(input logic [15:0] pin, input logic t, input logic l);
    logic rise;
    rise = t && !m_trigd;
    case (m_state)
      S_LOCKED: begin
        if (rise) begin
          if (pin == TB_PIN) begin
            m_state = S_UNLOCKED;
            m_fails = 0;
          end else begin
            m_fails++;
            if (m_fails == TB_MAX_FAILS) begin
              m_state     = S_LOCKOUT;
              m_remaining = TB_LOCKOUT;
            end
          end
        end
      end
      S_UNLOCKED: if (l) m_state = S_LOCKED;
      S_LOCKOUT: begin
        m_remaining--;
        if (m_remaining == 0) begin
          m_state = S_LOCKED;
          m_fails = 0;
        end
      end
      default: begin
        m_state = S_LOCKED;
        m_fails = 0;
      end
    endcase
    m_trigd = t;
  endtask

  // Starts and ends at a falling edge.
  task automatic cycle(input string tag, input logic [15:0] pin, input logic t, input logic l);
    sb_item_t item;
    pinCode = pin;
    trig    = t;
    lock    = l;
    model_step(pin, t, l);
    sb.push_back('{tag: tag, exp: m_state});
    @(posedge clk);
    #1;
    item = sb.pop_front();
    check(item.tag, {30'd0, state}, {30'd0, item.exp});
    if (state == S_LOCKOUT) lo_cnt++;
    @(negedge clk);
  endtask

  // trig high for 'hold' cycles, then low for one cycle.
  task automatic attempt(input string tag, input logic [15:0] pin, input int hold);
    for (int i = 0; i < hold; i++) cycle(tag, pin, 1'b1, 1'b0);
    cycle(tag, pin, 1'b0, 1'b0);
  endtask

  // Asserts rst between clock edges and checks that state clears before any
  // clock edge. Releases rst on a falling edge with trig at trig_lvl.
  task automatic do_reset(input string tag, input logic trig_lvl, input logic [15:0] pin);
    #2;
    rst = 1'b1;
    #1;
    check(tag, {30'd0, state}, {30'd0, S_LOCKED});
    model_reset();
    trig    = trig_lvl;
    pinCode = pin;
    lock    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);

    // Reset and idle.
    do_reset("reset_state", 1'b0, 16'h0000);
    cycle("idle_after_reset", 16'h0000, 1'b0, 1'b0);

    // Three wrong codes with long trig pulses, then the right one.
    attempt("wrong_abcd", 16'hABCD, 3);
    attempt("wrong_baba", 16'hBABA, 3);
    attempt("wrong_face", 16'hFACE, 3);
    attempt("unlock_caca", 16'hCACA, 2);

    // trig ignored while unlocked; lock relocks.
    attempt("unl_trig_ignored", 16'hCACA, 1);
    cycle("unl_lock", 16'h0000, 1'b0, 1'b1);

    // Four wrong codes -> lockout; attempts in lockout ignored; timed exit.
    lo_cnt = 0;
    attempt("dada_1", 16'hDADA, 1);
    attempt("dada_2", 16'hDADA, 1);
    attempt("dada_3", 16'hDADA, 1);
    attempt("dada_4", 16'hDADA, 1);
    attempt("lo_abba", 16'hABBA, 1);
    attempt("lo_caca", 16'hCACA, 1);
    cycle("lo_lock_ignored", 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 20 && m_state == S_LOCKOUT; i++)
      cycle("lo_wait", 16'h0000, 1'b0, 1'b0);
    check("lockout_len", 32'(lo_cnt), 32'(TB_LOCKOUT));
    attempt("post_lo_unlock", 16'hCACA, 1);
    cycle("relock_1", 16'h0000, 1'b0, 1'b1);

    // lock is ignored while locked.
    cycle("locked_lock_ignored", 16'h0000, 1'b0, 1'b1);
    cycle("locked_lock_and_pin", 16'hCACA, 1'b1, 1'b1);
    cycle("relock_2", 16'h0000, 1'b0, 1'b1);

    // trig held 10 cycles counts once; two more wrong stay locked.
    attempt("held_wrong", 16'h1111, 10);
    attempt("wrong_after_held_1", 16'h2222, 1);
    attempt("wrong_after_held_2", 16'h3333, 1);
    attempt("unlock_after_held", 16'hCACA, 1);

    // Async reset while unlocked, then with trig held across release.
    do_reset("rst_in_unlocked", 1'b1, 16'hCACA);
    for (int i = 0; i < 4; i++) cycle("trig_held_thru_rst", 16'hCACA, 1'b1, 1'b0);
    cycle("trig_low", 16'hCACA, 1'b0, 1'b0);
    cycle("trig_fresh_edge", 16'hCACA, 1'b1, 1'b0);
    cycle("trig_release", 16'hCACA, 1'b0, 1'b0);

    // Async reset in lockout; counters must be cleared.
    cycle("relock_3", 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) attempt("to_lockout", 16'h5555, 1);
    cycle("in_lockout", 16'h0000, 1'b0, 1'b0);
    do_reset("rst_in_lockout", 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) attempt("fails_cleared", 16'h6666, 1);
    attempt("unlock_after_rst", 16'hCACA, 1);

    // lock and a trig edge in the same cycle while unlocked: lock wins.
    cycle("lock_vs_trig", 16'hCACA, 1'b1, 1'b1);
    cycle("no_new_edge", 16'hCACA, 1'b1, 1'b0);
    cycle("trig_drop", 16'hCACA, 1'b0, 1'b0);

    if (sb.size() != 0) check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/combo_lock_state_machine.md
COMBO_LOCK_STATE_MACHINE -- requirements
Module: combo_lock_state_machine

Interface
REQ-001 Parameter PIN, default 16'hCACA: the unlock code.
REQ-002 Parameter MAX_FAILS, default 4: consecutive wrong attempts that trigger lockout (legal range 1..15).
REQ-003 Parameter LOCKOUT_CYCLES, default 1000: clock cycles spent in LOCKOUT before the automatic return to LOCKED (legal range 1..65535).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 pinCode  input  16  entered code, sampled on the clock edge where a trig rising edge is detected.
REQ-007 trig  input  1  submit request, level input; only its rising edge counts.
REQ-008 lock  input  1  relock request, level-sensitive.
REQ-009 state  output  2  registered current state: 2'b00 LOCKED, 2'b01 UNLOCKED, 2'b10 LOCKOUT.

Function
REQ-010 The block SHALL keep a registered copy trig_d of trig; a trig rising edge is trig=1 with trig_d=0 at a clock edge, so one attempt is counted per edge however long trig is held.
REQ-011 In LOCKED, on a trig edge with pinCode==PIN, the block SHALL go to UNLOCKED at that same clock edge and clear the fail counter.
REQ-012 In LOCKED, on a trig edge with pinCode!=PIN, the block SHALL increment the fail counter; when the new count equals MAX_FAILS it SHALL go to LOCKOUT at that edge and load the lockout timer with LOCKOUT_CYCLES.
REQ-013 In LOCKED, the lock input SHALL be ignored.
REQ-014 In UNLOCKED, lock=1 at a clock edge SHALL return the block to LOCKED at that edge; the fail counter stays 0.
REQ-015 In UNLOCKED, trig edges SHALL be ignored; if lock and a trig edge coincide, lock wins and the trig edge is discarded.
REQ-016 In LOCKOUT, trig edges (correct or wrong code) and lock SHALL be ignored.
REQ-017 In LOCKOUT, the timer SHALL decrement once per cycle; on the edge where it would reach 0 the block SHALL go to LOCKED with fail counter 0. State is therefore 2'b10 for exactly LOCKOUT_CYCLES cycles.
REQ-018 The fail counter SHALL count consecutive wrong attempts only; any successful unlock clears it.
REQ-019 The encoding 2'b11 is illegal; if reached, the block SHALL go to LOCKED with counters cleared on the next clock edge.
REQ-020 state SHALL come directly from a register, with no combinational path from inputs to state.

Reset
REQ-021 While rst=1, regardless of clk: state=2'b00 (LOCKED), fail counter=0, lockout timer=0, trig_d=1.
REQ-022 Because trig_d resets to 1, a trig held high across reset release SHALL NOT count as an attempt; trig must go low and then high again.
REQ-023 Asserting rst mid-lockout or while UNLOCKED SHALL abort that state immediately, with no wait for a clock edge.

Verification
REQ-024 Reset, then wrong codes 16'hABCD, 16'hBABA, 16'hFACE, each a trig pulse lasting several cycles -> state stays 2'b00, fail count reaches 3; then 16'hCACA -> state 2'b01, fail count 0.
REQ-025 In UNLOCKED, trig again with 16'hCACA -> state stays 2'b01; lock=1 for 1 cycle -> state 2'b00 at that edge.
REQ-026 From LOCKED, four 16'hDADA attempts -> state 2'b10 on the fourth trig edge; then 16'hABBA and 16'hCACA attempts -> state stays 2'b10.
REQ-027 In LOCKOUT, run LOCKOUT_CYCLES (set to 8 for test) -> state 2'b10 for exactly 8 cycles, then 2'b00; a following 16'hCACA attempt -> 2'b01.
REQ-028 trig held high for 10 cycles with a wrong code -> fail count +1 only; trig high through reset release -> no attempt counted.
REQ-029 Assert rst asynchronously between clock edges during LOCKOUT and during UNLOCKED -> state 2'b00 immediately, counters cleared; lock and a trig edge in the same cycle while UNLOCKED -> 2'b00.
